wisc_cpu: RTL and testbench
===========================

Name: wisc_cpu

Overview:
- Single-cycle 16-bit load/store processor (16 registers, byte-addressed, 2-byte instructions).
- Top of the phase-1 design: contains PC, register file, ALU, flags, control and the instruction and data memories.
- Exposes only the current PC and a halt indication.
- Named internal nets are probed hierarchically by the verification bench.

Parameters:
- ADDR_W, 16, memory address width; each memory holds 2^(ADDR_W-1) 16-bit words indexed by addr[ADDR_W-1:1].
- IMEM_FILE, "instructions.img", hex image loaded into instruction memory at time 0 via $readmemh.
- DMEM_FILE, "data.img", hex image loaded into data memory at time 0.

Ports:
- clk  in  1  Single clock; all state updates on rising edge.
- rst_n  in  1  Reset; asynchronous and active-low.
- pc  out  16  Address of the instruction currently executing.
- hlt  out  1  High while the current instruction is HLT.

Behaviour:
- Reset (rst_n=0, async): PC=0, R0..R15=0, flags Z=V=N=0. Memory contents are not cleared.
- Per cycle:
  - Fetch word at PC (combinational read).
  - Decode, execute, read data memory combinationally.
  - At the rising edge: write rd, write data memory, update flags, update PC.
- Required hierarchical debug nets:
  - instruction: fetched word.
  - programCount: equals pc.
  - RegWrite, WriteReg[3:0], data_in[15:0]: register write-back value.
  - MemRead, MemWrite.
  - result[15:0]: ALU output and memory address.
  - data_out[15:0]: store data.
- Encoding:
  - op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0].
  - imm4=[3:0], imm8=[7:0], ccc=[11:9], imm9=[8:0].
- Opcodes:
  - 0 ADD: rd=rs+rt, 16-bit signed saturating.
  - 1 SUB: rd=rs-rt, 16-bit signed saturating.
  - 2 XOR: rd=rs^rt.
  - 3 RED: rd=sign-extended sum of the 4 signed bytes of rs and rt.
  - 4 SLL: rd=rs<<imm4.
  - 5 SRA: rd=rs>>>imm4.
  - 6 ROR: rd=rs rotated right by imm4.
  - 7 PADDSB: four independent 4-bit signed saturating nibble adds.
  - 8 LW: R[11:8]=M[(rs&0xFFFE)+(sext(imm4)<<1)].
  - 9 SW: M[same address]=R[11:8].
  - A LLB: rd={rd[15:8],imm8}.
  - B LHB: rd={imm8,rd[7:0]}.
  - C B: if cond, PC=PC+2+(sext(imm9)<<1).
  - D BR: if cond, PC=R[7:4].
  - E PCS: rd=PC+2.
  - F HLT.
- Flags:
  - ADD/SUB set N, Z, V. V=1 when saturation occurred; N and Z reflect the saturated result.
  - XOR/SLL/SRA/ROR set Z only.
  - All other instructions leave flags unchanged.
- Conditions:
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 and N=0.
  - 011 LT: N=1.
  - 100 GE: Z=1 or (Z=0 and N=0).
  - 101 LE: N=1 or Z=1.
  - 110 OV: V=1.
  - 111: always.
- Branch not taken: PC=PC+2. Non-branch instructions: PC=PC+2, wrapping 0xFFFE to 0x0000.
- R0 reads as 0; writes to R0 are discarded. RegWrite may still assert for a write targeting R0.
- Register read during write of the same register returns the old value. The new value becomes visible next cycle.
- HLT: hlt=1 combinationally. PC holds; no register or memory writes occur. The CPU remains halted until reset.
- Reset asserted mid-program forces the reset state immediately and restarts fetch at 0 on release.

Decomposition:
- Shared package:
  - opcode localparams.
  - condition-code localparams.
  - flag bit indices.
- Natural sub-module: wisc_alu (ALU ops, saturation, flag generation).
- Register file and memories are inferred arrays inside wisc_cpu.

Test Plan:
- Reset/sequencing: hold rst_n low 2 cycles, program LLB R1,0x34; LHB R1,0x12; HLT → R1=0x1234, pc stops at 0x0004 with hlt=1.
- Saturation: R1=0x7FFF, R2=0x0001, ADD R3,R1,R2 → R3=0x7FFF, V=1. SUB with R1=0x8000, R2=1 → 0x8000, V=1.
- Memory: R4=0x0010, R5=0xBEEF, SW R5,R4,2 → MemWrite=1, result=0x0014. LW R6,R4,2 → R6=0xBEEF, MemRead=1.
- Branches: SUB R0,R1,R1 (Z=1), B EQ +2 → PC skips 2 instructions. B NE not taken → PC+2.
- BR/PCS: PCS R7 at 0x0020 → R7=0x0022. BR always R7 → pc=0x0022.
- R0/shift: LLB R0,0xFF → R0 reads 0. R1=0x8001: SRA 1 → 0xC000, ROR 1 → 0xC000, SLL 1 → 0x0002.

Source files
------------

// File: rtl/wisc_cpu_pkg.sv
// Shared definitions for the WISC single-cycle CPU: opcodes, branch
// condition codes, flag bit positions and small datapath helpers.
package wisc_cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    CC_NE = 3'b000,
    CC_EQ = 3'b001,
    CC_GT = 3'b010,
    CC_LT = 3'b011,
    CC_GE = 3'b100,
    CC_LE = 3'b101,
    CC_OV = 3'b110,
    CC_AL = 3'b111
  } cond_e;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 2;

  // 4-bit signed add clamped to [-8, 7]
  function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {a[3], a} + {b[3], b};
    if (s[4] != s[3]) return a[3] ? 4'h8 : 4'h7;
    return s[3:0];
  endfunction

  // Branch condition evaluation against the current flags
  function automatic logic cond_met(input cond_e cc, input logic [2:0] flags);
    logic z, v, n, r;
    z = flags[FLAG_Z];
    v = flags[FLAG_V];
    n = flags[FLAG_N];
    case (cc)
      CC_NE:   r = !z;
      CC_EQ:   r = z;
      CC_GT:   r = !z && !n;
      CC_LT:   r = n;
      CC_GE:   r = z || (!z && !n);
      CC_LE:   r = n || z;
      CC_OV:   r = v;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wisc_alu.sv
// WISC ALU: arithmetic/logic ops with saturation, memory address
// generation, byte-load merges and flag generation.
module wisc_alu
  import wisc_cpu_pkg::*;
(
  input  opcode_e     op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [7:0]  imm8,
  output logic [15:0] result,
  output logic [2:0]  flags_new,
  output logic [2:0]  flags_we
);

  logic [3:0]  imm4;
  logic [16:0] sum_ext;
  logic [16:0] diff_ext;
  logic        add_ovf;
  logic        sub_ovf;
  logic [15:0] add_sat;
  logic [15:0] sub_sat;
  logic [9:0]  red_raw;
  logic [15:0] paddsb_res;
  logic [15:0] mem_addr;

  // Datapath evaluation and result/flag selection by opcode
  always_comb begin
    imm4     = imm8[3:0];
    sum_ext  = {a[15], a} + {b[15], b};
    diff_ext = {a[15], a} - {b[15], b};
    add_ovf  = sum_ext[16] ^ sum_ext[15];
    sub_ovf  = diff_ext[16] ^ diff_ext[15];
    add_sat  = add_ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : sum_ext[15:0];
    sub_sat  = sub_ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : diff_ext[15:0];
    red_raw  = {{2{a[15]}}, a[15:8]} + {{2{a[7]}}, a[7:0]}
             + {{2{b[15]}}, b[15:8]} + {{2{b[7]}}, b[7:0]};
    paddsb_res = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      paddsb_res[4*i +: 4] = sat_add4(a[4*i +: 4], b[4*i +: 4]);
    end
    mem_addr = (a & 16'hFFFE) + {{11{imm4[3]}}, imm4, 1'b0};

    result   = '0;
    flags_we = '0;
    case (op)
      OP_ADD:    begin result = add_sat; flags_we = '1; end
      OP_SUB:    begin result = sub_sat; flags_we = '1; end
      OP_XOR:    begin result = a ^ b; flags_we[FLAG_Z] = 1'b1; end
      OP_RED:    result = {{6{red_raw[9]}}, red_raw};
      OP_SLL:    begin result = a << imm4; flags_we[FLAG_Z] = 1'b1; end
      OP_SRA:    begin result = $signed(a) >>> imm4; flags_we[FLAG_Z] = 1'b1; end
      OP_ROR:    begin
        result = (a >> imm4) | (a << (5'd16 - {1'b0, imm4}));
        flags_we[FLAG_Z] = 1'b1;
      end
      OP_PADDSB: result = paddsb_res;
      OP_LW,
      OP_SW:     result = mem_addr;
      OP_LLB:    result = {b[15:8], imm8};
      OP_LHB:    result = {imm8, b[7:0]};
      default:   result = '0;
    endcase

    flags_new[FLAG_Z] = (result == '0);
    flags_new[FLAG_N] = result[15];
    flags_new[FLAG_V] = (op == OP_SUB) ? sub_ovf : add_ovf;
  end

endmodule

// File: rtl/wisc_cpu.sv
// WISC single-cycle 16-bit CPU top: PC, register file, flags, control,
// instruction and data memories.
module wisc_cpu
  import wisc_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter string       IMEM_FILE = "instructions.img",
  parameter string       DMEM_FILE = "data.img"
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc,
  output logic        hlt
);

  localparam int unsigned MEM_WORDS = 2 ** (ADDR_W - 1);

  logic [15:0] imem [MEM_WORDS];
  logic [15:0] dmem [MEM_WORDS];
  logic [15:0] rf_q [16];
  logic [15:0] pc_q, pc_d;
  logic [2:0]  flags_q, flags_d;

  logic [15:0] instruction;
  logic [15:0] programCount;
  logic        RegWrite;
  logic [3:0]  WriteReg;
  logic [15:0] data_in;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] result;
  logic [15:0] data_out;

  opcode_e     op;
  cond_e       cc;
  logic [3:0]  rs_idx, rt_idx;
  logic [15:0] rs_val, rt_val;
  logic [15:0] pc_plus2, br_target, mem_rdata;
  logic [2:0]  flags_new, flags_we;
  logic        taken;

  assign instruction  = imem[pc_q[ADDR_W-1:1]];
  assign pc           = pc_q;
  assign programCount = pc_q;
  assign rs_val       = rf_q[rs_idx];
  assign rt_val       = rf_q[rt_idx];
  assign mem_rdata    = dmem[result[ADDR_W-1:1]];

  wisc_alu u_alu (
    .op        (op),
    .a         (rs_val),
    .b         (rt_val),
    .imm8      (instruction[7:0]),
    .result    (result),
    .flags_new (flags_new),
    .flags_we  (flags_we)
  );

  // Decode, write-back selection and next-PC/flag computation
  always_comb begin
    op       = opcode_e'(instruction[15:12]);
    cc       = cond_e'(instruction[11:9]);
    rs_idx   = instruction[7:4];
    // SW stores rd, LLB/LHB merge into rd, so these read rd on the second port
    rt_idx   = (op == OP_SW || op == OP_LLB || op == OP_LHB) ? instruction[11:8]
                                                             : instruction[3:0];
    WriteReg = instruction[11:8];
    hlt      = (op == OP_HLT);
    MemRead  = (op == OP_LW);
    MemWrite = (op == OP_SW);
    RegWrite = !(op == OP_SW || op == OP_B || op == OP_BR || op == OP_HLT);
    data_out = rt_val;

    pc_plus2  = pc_q + 16'd2;
    br_target = pc_plus2 + {{6{instruction[8]}}, instruction[8:0], 1'b0};
    taken     = cond_met(cc, flags_q);

    data_in = result;
    if (op == OP_LW)  data_in = mem_rdata;
    if (op == OP_PCS) data_in = pc_plus2;

    pc_d = pc_plus2;
    case (op)
      OP_B:    if (taken) pc_d = br_target;
      OP_BR:   if (taken) pc_d = rs_val;
      OP_HLT:  pc_d = pc_q;
      default: pc_d = pc_plus2;
    endcase

    flags_d = (flags_q & ~flags_we) | (flags_new & flags_we);
  end

  // PC and flag state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      flags_q <= '0;
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

  // Register file; R0 is never written so it always reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (RegWrite && WriteReg != 4'd0) begin
      rf_q[WriteReg] <= data_in;
    end
  end

  // Data memory write port; suppressed while reset is held
  always_ff @(posedge clk) begin
    if (MemWrite && rst_n) dmem[result[ADDR_W-1:1]] <= data_out;
  end

endmodule

// File: tb/tb_wisc_cpu.sv
// Self-checking bench for wisc_cpu: table of small programs with expected
// end state, plus hand-written cycle sequences for debug nets and reset.
module tb_wisc_cpu;
  import wisc_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic        hlt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  wisc_cpu #(
    .ADDR_W    (16),
    .IMEM_FILE (""),
    .DMEM_FILE ("")
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pc    (pc),
    .hlt   (hlt)
  );

  always #5 clk = ~clk;

  typedef enum int {K_REG, K_PC, K_HLT, K_FLAGS} kind_e;

  typedef struct {
    logic [8*12-1:0] name;
    kind_e           kind;
    int unsigned     idx;
    logic [15:0]     mask;
    logic [15:0]     exp;
  } exp_t;

  typedef struct {
    logic [8*12-1:0] name;
    int unsigned     base;
    int unsigned     len;
    int unsigned     reg_idx;
    logic [15:0]     reg_exp;
    logic [15:0]     pc_exp;
    logic            hlt_exp;
    logic [2:0]      fmask;   // {N,V,Z}
    logic [2:0]      fexp;    // {N,V,Z}
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[16];
  logic [15:0] progs[64];

  task automatic chk(input logic [8*12-1:0] name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] flags_nvz();
    return {13'd0, dut.flags_q[FLAG_N], dut.flags_q[FLAG_V], dut.flags_q[FLAG_Z]};
  endfunction

  task automatic load_prog(input int unsigned base, input int unsigned len);
    rst_n = 1'b0;
    for (int i = 0; i < 32768; i++) dut.imem[i] = 16'hF000;
    for (int unsigned i = 0; i < len; i++) dut.imem[i] = progs[base + i];
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_pc(input logic [15:0] target, input int unsigned budget);
    for (int unsigned c = 0; c < budget; c++) begin
      if (pc === target) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [15:0] act;

    // P0 base 0: LLB R1,34; LHB R1,12; HLT
    progs[0] = 16'hA134; progs[1] = 16'hB112; progs[2] = 16'hF000;
    // P1 base 3: R1=7FFF, R2=1, ADD R3,R1,R2
    progs[3] = 16'hA1FF; progs[4] = 16'hB17F; progs[5] = 16'hA201;
    progs[6] = 16'h0312; progs[7] = 16'hF000;
    // P2 base 8: R1=8000, R2=1, SUB R3,R1,R2
    progs[8]  = 16'hA100; progs[9]  = 16'hB180; progs[10] = 16'hA201;
    progs[11] = 16'h1312; progs[12] = 16'hF000;
    // P3 base 13: R4=10, R5=BEEF, SW R5,R4,2; LW R6,R4,2
    progs[13] = 16'hA410; progs[14] = 16'hA5EF; progs[15] = 16'hB5BE;
    progs[16] = 16'h9542; progs[17] = 16'h8642; progs[18] = 16'hF000;
    // P4 base 19: R1=5; SUB R0,R1,R1; B EQ +2; skipped x2; B NE +1; LLB R3,33; HLT
    progs[19] = 16'hA105; progs[20] = 16'h1011; progs[21] = 16'hC202;
    progs[22] = 16'hA211; progs[23] = 16'hA222; progs[24] = 16'hC001;
    progs[25] = 16'hA333; progs[26] = 16'hF000;
    // P5 base 27: B always to 0x20; PCS R7 at 0x20; BR always R7
    progs[27] = 16'hCE0F;
    for (int unsigned i = 28; i < 43; i++) progs[i] = 16'hF000;
    progs[43] = 16'hE700; progs[44] = 16'hDE70;
    // P6 base 45: LLB R0,FF; R1=8001; SRA/ROR/SLL by 1; XOR R5,R1,R1
    progs[45] = 16'hA0FF; progs[46] = 16'hA101; progs[47] = 16'hB180;
    progs[48] = 16'h5211; progs[49] = 16'h6311; progs[50] = 16'h4411;
    progs[51] = 16'h2511; progs[52] = 16'hF000;
    // P7 base 53: R1=7A85, R2=1653, PADDSB R3; RED R4
    progs[53] = 16'hA185; progs[54] = 16'hB17A; progs[55] = 16'hA253;
    progs[56] = 16'hB216; progs[57] = 16'h7312; progs[58] = 16'h3412;
    progs[59] = 16'hF000;
    for (int unsigned i = 60; i < 64; i++) progs[i] = 16'hF000;

    vecs[0]  = '{"seq_r1",   0,  3, 1, 16'h1234, 16'h0004, 1'b1, 3'b000, 3'b000};
    vecs[1]  = '{"add_sat",  3,  5, 3, 16'h7FFF, 16'h0008, 1'b1, 3'b111, 3'b010};
    vecs[2]  = '{"add_src",  3,  5, 1, 16'h7FFF, 16'h0008, 1'b1, 3'b000, 3'b000};
    vecs[3]  = '{"sub_sat",  8,  5, 3, 16'h8000, 16'h0008, 1'b1, 3'b111, 3'b110};
    vecs[4]  = '{"lw_data",  13, 6, 6, 16'hBEEF, 16'h000A, 1'b1, 3'b000, 3'b000};
    vecs[5]  = '{"beq_skip", 19, 8, 2, 16'h0000, 16'h000E, 1'b1, 3'b111, 3'b001};
    vecs[6]  = '{"bne_fall", 19, 8, 3, 16'h0033, 16'h000E, 1'b1, 3'b000, 3'b000};
    vecs[7]  = '{"sub_r0",   19, 8, 0, 16'h0000, 16'h000E, 1'b1, 3'b000, 3'b000};
    vecs[8]  = '{"pcs_br",   27, 18, 7, 16'h0022, 16'h0022, 1'b0, 3'b000, 3'b000};
    vecs[9]  = '{"llb_r0",   45, 8, 0, 16'h0000, 16'h000E, 1'b1, 3'b000, 3'b000};
    vecs[10] = '{"sra",      45, 8, 2, 16'hC000, 16'h000E, 1'b1, 3'b000, 3'b000};
    vecs[11] = '{"ror",      45, 8, 3, 16'hC000, 16'h000E, 1'b1, 3'b000, 3'b000};
    vecs[12] = '{"sll",      45, 8, 4, 16'h0002, 16'h000E, 1'b1, 3'b000, 3'b000};
    vecs[13] = '{"xor",      45, 8, 5, 16'h0000, 16'h000E, 1'b1, 3'b111, 3'b001};
    vecs[14] = '{"paddsb",   53, 7, 3, 16'h70D7, 16'h000C, 1'b1, 3'b000, 3'b000};
    vecs[15] = '{"red",      53, 7, 4, 16'h0068, 16'h000C, 1'b1, 3'b111, 3'b000};

    // Reset state before anything runs
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_r1", dut.rf_q[1], 16'h0000);
    chk("rst_flags", flags_nvz(), 16'h0000);

    // Table-driven programs: expectations queued at launch, checked at end
    for (int unsigned v = 0; v < 16; v++) begin
      load_prog(vecs[v].base, vecs[v].len);
      sb.push_back('{vecs[v].name, K_REG, vecs[v].reg_idx, 16'hFFFF, vecs[v].reg_exp});
      sb.push_back('{vecs[v].name, K_PC, 0, 16'hFFFF, vecs[v].pc_exp});
      sb.push_back('{vecs[v].name, K_HLT, 0, 16'h0001, {15'd0, vecs[v].hlt_exp}});
      if (vecs[v].fmask != 3'b000)
        sb.push_back('{vecs[v].name, K_FLAGS, 0, {13'd0, vecs[v].fmask}, {13'd0, vecs[v].fexp}});
      repeat (24) @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.kind)
          K_REG:   act = dut.rf_q[e.idx];
          K_PC:    act = pc;
          K_HLT:   act = {15'd0, hlt};
          default: act = flags_nvz();
        endcase
        chk(e.name, act & e.mask, e.exp);
      end
    end

    // Store/load debug nets cycle by cycle
    load_prog(13, 6);
    wait_pc(16'h0006, 20);
    chk("reach_sw", pc, 16'h0006);
    chk("prog_count", dut.programCount, 16'h0006);
    chk("sw_memwr", 16'(dut.MemWrite), 16'h0001);
    chk("sw_addr", dut.result, 16'h0014);
    chk("sw_data", dut.data_out, 16'hBEEF);
    chk("sw_regwr", 16'(dut.RegWrite), 16'h0000);
    @(negedge clk);
    chk("lw_pc", pc, 16'h0008);
    chk("lw_memrd", 16'(dut.MemRead), 16'h0001);
    chk("lw_datain", dut.data_in, 16'hBEEF);
    chk("lw_wreg", 16'(dut.WriteReg), 16'h0006);
    chk("lw_regwr", 16'(dut.RegWrite), 16'h0001);
    repeat (3) @(negedge clk);
    chk("hlt_hold", pc, 16'h000A);
    chk("hlt_nowr", 16'(dut.MemWrite), 16'h0000);

    // Write to R0 still asserts RegWrite but is discarded
    load_prog(45, 8);
    chk("r0_regwr", 16'(dut.RegWrite), 16'h0001);
    chk("r0_wreg", 16'(dut.WriteReg), 16'h0000);
    chk("r0_datain", dut.data_in, 16'h00FF);
    @(negedge clk);
    chk("r0_read", dut.rf_q[0], 16'h0000);
    repeat (10) @(negedge clk);
    chk("pre_rst_r2", dut.rf_q[2], 16'hC000);

    // Asynchronous reset mid-run, then restart from 0
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 16'h0000);
    chk("arst_r2", dut.rf_q[2], 16'h0000);
    chk("arst_flags", flags_nvz(), 16'h0000);

    load_prog(27, 18);
    repeat (5) @(negedge clk);
    chk("loop_pc", pc, 16'h0022);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst2_pc", pc, 16'h0000);
    chk("arst2_r7", dut.rf_q[7], 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_pc", pc, 16'h0020);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
